// File: rtl/fpu_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_cmd_queue
//  Purpose  : Command FIFO and single-issue controller placed directly in
//             front of the floating-point unit. Commands {a, b, op} are
//             buffered in a circular buffer and issued one at a time over the
//             FPU input handshake. A new command is issued only after the
//             previous FPU result has been consumed.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset          : clock; asynchronous active-high reset
//    cmd_rdy / cmd_ack     : producer handshake (cmd_ack = !full && !flush)
//    cmd_a, cmd_b, cmd_op  : command operands and opcode (0 add,1 sub,2 mul,3 div)
//    flush                 : synchronous discard of all un-issued commands
//    fpu_input_rdy/_ack    : issue handshake toward the FPU
//    fpu_data_a/_b, fpu_operation : head-of-queue command
//    fpu_output_rdy/_ack   : monitored FPU result handshake
//    count, full, empty    : occupancy status
//    err_illegal_op        : sticky reserved-opcode flag
//  Build option
//    FPU_CMDQ_OPCHECK_EN   : when defined, reserved opcodes (> 3) are
//                            acknowledged but dropped, and err_illegal_op is
//                            set until reset. Otherwise every opcode is
//                            forwarded and err_illegal_op is tied low.
// ============================================================================
module fpu_cmd_queue #(
    parameter int bitness = 32,
    parameter int depth   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_rdy,
    output logic                       cmd_ack,
    input  logic [bitness-1:0]         cmd_a,
    input  logic [bitness-1:0]         cmd_b,
    input  logic [3:0]                 cmd_op,
    input  logic                       flush,
    output logic                       fpu_input_rdy,
    input  logic                       fpu_input_ack,
    output logic [bitness-1:0]         fpu_data_a,
    output logic [bitness-1:0]         fpu_data_b,
    output logic [3:0]                 fpu_operation,
    input  logic                       fpu_output_rdy,
    input  logic                       fpu_output_ack,
    output logic [$clog2(depth):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       err_illegal_op
);

    localparam int c_PTR_W = $clog2(depth);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 2 * bitness + 4;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(depth);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE  = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;

    logic [c_ENT_W-1:0] r_mem [depth];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               w_cmd_ack;
    logic               w_push;
    logic               w_store;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_issue;
    logic [c_ENT_W-1:0] w_head;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_cmd_ack = !w_full && !flush;
    assign w_push    = cmd_rdy && w_cmd_ack;
    assign w_pop     = w_issue && fpu_input_ack;

`ifdef FPU_CMDQ_OPCHECK_EN
    logic w_op_ok;
    logic r_err;

    // Reserved opcodes are still acknowledged so the producer never stalls
    // on them; they are simply not written into the buffer.
    assign w_op_ok = (cmd_op <= 4'd3);
    assign w_store = w_push && w_op_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_push && !w_op_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err_illegal_op = r_err;
`else
    assign w_store        = w_push;
    assign err_illegal_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage: contents need no reset, only the pointers qualify them.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Flush wins over a same-cycle pop: the popped command is already
            // in the FPU, the rest of the queue is discarded.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty && !flush) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                // An ack in the flush cycle still hands the command over,
                // so the result must be waited for.
                if (fpu_input_ack) begin
                    w_state_nxt = c_ST_WAIT;
                end else if (flush) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                if (fpu_output_rdy && fpu_output_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Issue FSM: output logic
    always_comb begin
        w_issue = 1'b0;
        if (r_state == c_ST_ISSUE) begin
            w_issue = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_head        = r_mem[r_rd_ptr];
    assign fpu_data_a    = w_head[c_ENT_W-1 -: bitness];
    assign fpu_data_b    = w_head[4 +: bitness];
    assign fpu_operation = w_head[3:0];
    assign fpu_input_rdy = w_issue;
    assign cmd_ack       = w_cmd_ack;
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;

endmodule

`default_nettype wire
